kan_layer_pass_sequencer: RTL and testbench

- Sequences one KAN layer job across the parallelized data processor (RSWAF activation plus linear processing array).
- Tiles a layer of IN_FEATURES x OUT_FEATURES into passes sized DATA_CHANNELS x RSLT_CHANNELS and issues one pass command per tile to the stream sources (data, grid, weight DMAs).
- Marks the first and last input tile of every output tile, so the array clears and emits its accumulators at the correct pass.
- Waits for per-pass completion from the result stream before issuing the next pass.

---
 rtl/kan_layer_pass_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_kan_layer_pass_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kan_layer_pass_sequencer.sv
// Tiles one KAN layer job into DATA_CHANNELS x RSLT_CHANNELS passes and issues
// one pass command per tile, input tiles inner, output tiles outer.
module kan_layer_pass_sequencer #(
    parameter int unsigned DATA_CHANNELS = 1,
    parameter int unsigned RSLT_CHANNELS = 1,
    parameter int unsigned FEAT_WIDTH    = 16,
    parameter int unsigned GRID_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [FEAT_WIDTH-1:0]    cfg_in_features,
    input  logic [FEAT_WIDTH-1:0]    cfg_out_features,
    input  logic [GRID_WIDTH-1:0]    cfg_grid_size,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [FEAT_WIDTH-1:0]    cmd_in_base,
    output logic [FEAT_WIDTH-1:0]    cmd_out_base,
    output logic [DATA_CHANNELS-1:0] cmd_data_mask,
    output logic [RSLT_CHANNELS-1:0] cmd_rslt_mask,
    output logic [GRID_WIDTH-1:0]    cmd_weight_len,
    output logic                     cmd_first,
    output logic                     cmd_last,
    input  logic                     pass_done,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    output logic                     err_spurious
);

    // One extra bit so index + lane count never wraps at the maximum feature count
    localparam int unsigned XW = FEAT_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [FEAT_WIDTH-1:0]    in_feat_q, in_feat_d;
    logic [FEAT_WIDTH-1:0]    out_feat_q, out_feat_d;
    logic [GRID_WIDTH-1:0]    grid_q, grid_d;
    logic [FEAT_WIDTH-1:0]    in_idx_q, in_idx_d;
    logic [FEAT_WIDTH-1:0]    out_idx_q, out_idx_d;
    logic                     cfg_ready_q, cfg_ready_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [FEAT_WIDTH-1:0]    in_base_q, in_base_d;
    logic [FEAT_WIDTH-1:0]    out_base_q, out_base_d;
    logic [DATA_CHANNELS-1:0] data_mask_q, data_mask_d;
    logic [RSLT_CHANNELS-1:0] rslt_mask_q, rslt_mask_d;
    logic [GRID_WIDTH-1:0]    weight_len_q, weight_len_d;
    logic                     first_q, first_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_cfg_q, err_cfg_d;
    logic                     err_spur_q, err_spur_d;
    logic [XW-1:0]            in_next_x;
    logic [XW-1:0]            out_next_x;

    // State, descriptor, index and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            in_feat_q    <= '0;
            out_feat_q   <= '0;
            grid_q       <= '0;
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            cfg_ready_q  <= 1'b1;
            cmd_valid_q  <= 1'b0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            data_mask_q  <= '0;
            rslt_mask_q  <= '0;
            weight_len_q <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_cfg_q    <= 1'b0;
            err_spur_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_feat_q    <= in_feat_d;
            out_feat_q   <= out_feat_d;
            grid_q       <= grid_d;
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            cfg_ready_q  <= cfg_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            in_base_q    <= in_base_d;
            out_base_q   <= out_base_d;
            data_mask_q  <= data_mask_d;
            rslt_mask_q  <= rslt_mask_d;
            weight_len_q <= weight_len_d;
            first_q      <= first_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_cfg_q    <= err_cfg_d;
            err_spur_q   <= err_spur_d;
        end
    end

    // Next state, tile walk and next registered outputs
    always_comb begin
        state_d    = state_q;
        in_feat_d  = in_feat_q;
        out_feat_d = out_feat_q;
        grid_d     = grid_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        err_cfg_d  = err_cfg_q;
        err_spur_d = err_spur_q;
        in_next_x  = XW'(in_idx_q) + XW'(DATA_CHANNELS);
        out_next_x = XW'(out_idx_q) + XW'(RSLT_CHANNELS);

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    in_feat_d  = cfg_in_features;
                    out_feat_d = cfg_out_features;
                    grid_d     = cfg_grid_size;
                    err_cfg_d  = 1'b0;
                    err_spur_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                in_idx_d  = '0;
                out_idx_d = '0;
                if ((in_feat_q == '0) || (out_feat_q == '0)) begin
                    err_cfg_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pass_done) begin
                    if (in_next_x < XW'(in_feat_q)) begin
                        in_idx_d = FEAT_WIDTH'(in_next_x);
                        state_d  = S_ISSUE;
                    end else if (out_next_x < XW'(out_feat_q)) begin
                        in_idx_d  = '0;
                        out_idx_d = FEAT_WIDTH'(out_next_x);
                        state_d   = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pass_done && (state_q != S_WAIT)) begin
            err_spur_d = 1'b1;
        end
        // Abort overrides any handshake or pass completion in the same cycle
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        cfg_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        cmd_valid_d  = (state_d == S_ISSUE);
        in_base_d    = in_idx_d;
        out_base_d   = out_idx_d;
        weight_len_d = grid_d;
        first_d      = (in_idx_d == '0);
        last_d       = (XW'(in_idx_d) + XW'(DATA_CHANNELS)) >= XW'(in_feat_d);
        data_mask_d  = '0;
        rslt_mask_d  = '0;
        for (int unsigned k = 0; k < DATA_CHANNELS; k++) begin
            data_mask_d[k] = (XW'(in_idx_d) + XW'(k)) < XW'(in_feat_d);
        end
        for (int unsigned k = 0; k < RSLT_CHANNELS; k++) begin
            rslt_mask_d[k] = (XW'(out_idx_d) + XW'(k)) < XW'(out_feat_d);
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_in_base    = in_base_q;
    assign cmd_out_base   = out_base_q;
    assign cmd_data_mask  = data_mask_q;
    assign cmd_rslt_mask  = rslt_mask_q;
    assign cmd_weight_len = weight_len_q;
    assign cmd_first      = first_q;
    assign cmd_last       = last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cfg        = err_cfg_q;
    assign err_spurious   = err_spur_q;

endmodule

// File: tb/tb_kan_layer_pass_sequencer.sv
// Scoreboard bench: expected pass commands are queued per job and popped on
// each command handshake; a responder returns pass_done after each accept.
module tb_kan_layer_pass_sequencer;

    localparam int DC       = 4;
    localparam int RC       = 2;
    localparam int PD_DELAY = 5;

    typedef struct packed {
        logic [15:0] in_base;
        logic [15:0] out_base;
        logic [3:0]  dmask;
        logic [1:0]  rmask;
        logic [7:0]  wlen;
        logic        first;
        logic        last;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_in_features;
    logic [15:0] cfg_out_features;
    logic [7:0]  cfg_grid_size;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_in_base;
    logic [15:0] cmd_out_base;
    logic [3:0]  cmd_data_mask;
    logic [1:0]  cmd_rslt_mask;
    logic [7:0]  cmd_weight_len;
    logic        cmd_first;
    logic        cmd_last;
    logic        pass_done;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic        err_spurious;

    logic        pd_auto;
    logic        pd_force;
    logic        pd_en;
    int          pd_cnt;
    int          n_checks;
    int          n_errors;
    int          n_hs;
    int          n_done;
    int          n_valid;
    logic        prev_stall;
    cmd_t        prev_cmd;
    cmd_t        exp_q[$];

    assign pass_done = pd_auto | pd_force;

    kan_layer_pass_sequencer #(
        .DATA_CHANNELS(4),
        .RSLT_CHANNELS(2),
        .FEAT_WIDTH(16),
        .GRID_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_in_features(cfg_in_features),
        .cfg_out_features(cfg_out_features),
        .cfg_grid_size(cfg_grid_size),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_in_base(cmd_in_base),
        .cmd_out_base(cmd_out_base),
        .cmd_data_mask(cmd_data_mask),
        .cmd_rslt_mask(cmd_rslt_mask),
        .cmd_weight_len(cmd_weight_len),
        .cmd_first(cmd_first),
        .cmd_last(cmd_last),
        .pass_done(pass_done),
        .abort(abort),
        .busy(busy),
        .done(done),
        .err_cfg(err_cfg),
        .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_job(input int inf, input int outf, input int grid);
        cmd_t e;
        for (int o = 0; o < outf; o += RC) begin
            for (int i = 0; i < inf; i += DC) begin
                e.in_base  = 16'(i);
                e.out_base = 16'(o);
                for (int k = 0; k < DC; k++) e.dmask[k] = (i + k < inf);
                for (int k = 0; k < RC; k++) e.rmask[k] = (o + k < outf);
                e.wlen  = 8'(grid);
                e.first = (i == 0);
                e.last  = (i + DC >= inf);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.in_base  = cmd_in_base;
        c.out_base = cmd_out_base;
        c.dmask    = cmd_data_mask;
        c.rmask    = cmd_rslt_mask;
        c.wlen     = cmd_weight_len;
        c.first    = cmd_first;
        c.last     = cmd_last;
        return c;
    endfunction

    // One clock: monitor and responder at the falling edge, return just after the rising edge
    task automatic cycle();
        cmd_t e;
        cmd_t c;
        @(negedge clk);
        c = cur_cmd();
        pd_auto = 1'b0;
        if (pd_cnt > 0) begin
            pd_cnt--;
            if (pd_cnt == 0) pd_auto = 1'b1;
        end
        if (rst) begin
            if (done) n_done++;
            if (cmd_valid) n_valid++;
            if (prev_stall) begin
                chk("stall_valid_held", 64'(cmd_valid), 64'(1));
                if (cmd_valid) chk("stall_fields_stable", 64'(c), 64'(prev_cmd));
            end
            if (cmd_valid && cmd_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    chk("cmd_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_in_base", 64'(c.in_base), 64'(e.in_base));
                    chk("cmd_out_base", 64'(c.out_base), 64'(e.out_base));
                    chk("cmd_data_mask", 64'(c.dmask), 64'(e.dmask));
                    chk("cmd_rslt_mask", 64'(c.rmask), 64'(e.rmask));
                    chk("cmd_weight_len", 64'(c.wlen), 64'(e.wlen));
                    chk("cmd_first", 64'(c.first), 64'(e.first));
                    chk("cmd_last", 64'(c.last), 64'(e.last));
                end
                if (pd_en) pd_cnt = PD_DELAY;
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_cmd   = c;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int inf, input int outf, input int grid, input bit expect_cmd);
        push_job(inf, outf, grid);
        chk("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        cfg_valid        = 1'b1;
        cfg_in_features  = 16'(inf);
        cfg_out_features = 16'(outf);
        cfg_grid_size    = 8'(grid);
        cycle();
        cfg_valid = 1'b0;
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_cfg_ready", 64'(cfg_ready), 64'(0));
        chk("load_no_cmd", 64'(cmd_valid), 64'(0));
        cycle();
        chk("first_cmd_latency", 64'(cmd_valid), 64'(expect_cmd));
    endtask

    task automatic wait_hs(input int target, input int budget);
        int t = 0;
        while (n_hs < target && t < budget) begin
            cycle();
            t++;
        end
        if (n_hs < target) chk("wait_hs_timeout", 64'(n_hs), 64'(target));
    endtask

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!cmd_valid && t < budget) begin
            cycle();
            t++;
        end
        if (!cmd_valid) chk("wait_valid_timeout", 64'(cmd_valid), 64'(1));
    endtask

    task automatic wait_done(input int target, input int budget);
        int t = 0;
        while (n_done < target && t < budget) begin
            cycle();
            t++;
        end
        if (n_done < target) chk("wait_done_timeout", 64'(n_done), 64'(target));
    endtask

    initial begin
        int hs0;
        int d0;
        int v0;
        rst = 1'b0; cfg_valid = 1'b0; cfg_in_features = '0; cfg_out_features = '0;
        cfg_grid_size = '0; cmd_ready = 1'b1; abort = 1'b0; pd_force = 1'b0;
        pd_auto = 1'b0; pd_en = 1'b1; pd_cnt = 0; n_checks = 0; n_errors = 0;
        n_hs = 0; n_done = 0; n_valid = 0; prev_stall = 1'b0; prev_cmd = '0;
        repeat (3) cycle();
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err_cfg", 64'(err_cfg), 64'(0));
        chk("rst_err_spurious", 64'(err_spurious), 64'(0));
        chk("rst_in_base", 64'(cmd_in_base), 64'(0));
        rst = 1'b1;
        cycle();

        // Full 10x3 layer, always-ready sources
        hs0 = n_hs; d0 = n_done;
        start_job(10, 3, 8, 1'b1);
        wait_done(d0 + 1, 200);
        repeat (4) cycle();
        chk("t1_cmd_count", 64'(n_hs - hs0), 64'(6));
        chk("t1_done_count", 64'(n_done - d0), 64'(1));
        chk("t1_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("t1_idle_ready", 64'(cfg_ready), 64'(1));
        chk("t1_idle_busy", 64'(busy), 64'(0));

        // Same job, pass 2 back-pressured for 7 cycles
        hs0 = n_hs; d0 = n_done;
        start_job(10, 3, 8, 1'b1);
        wait_hs(hs0 + 1, 50);
        cmd_ready = 1'b0;
        wait_valid(50);
        chk("t2_stall_in_base", 64'(cmd_in_base), 64'(4));
        repeat (7) cycle();
        cmd_ready = 1'b1;
        wait_done(d0 + 1, 200);
        repeat (3) cycle();
        chk("t2_cmd_count", 64'(n_hs - hs0), 64'(6));
        chk("t2_done_count", 64'(n_done - d0), 64'(1));

        // Single tile
        hs0 = n_hs; d0 = n_done;
        start_job(4, 2, 8, 1'b1);
        wait_done(d0 + 1, 100);
        repeat (3) cycle();
        chk("t3_cmd_count", 64'(n_hs - hs0), 64'(1));
        chk("t3_done_count", 64'(n_done - d0), 64'(1));

        // Zero input features
        hs0 = n_hs; d0 = n_done; v0 = n_valid;
        start_job(0, 5, 8, 1'b0);
        chk("t4_done_pulse", 64'(done), 64'(1));
        chk("t4_err_cfg", 64'(err_cfg), 64'(1));
        cycle();
        chk("t4_done_cleared", 64'(done), 64'(0));
        chk("t4_idle_ready", 64'(cfg_ready), 64'(1));
        chk("t4_err_cfg_sticky", 64'(err_cfg), 64'(1));
        repeat (3) cycle();
        chk("t4_no_cmd", 64'(n_valid - v0), 64'(0));
        chk("t4_done_count", 64'(n_done - d0), 64'(1));
        d0 = n_done;
        start_job(4, 2, 8, 1'b1);
        chk("t4_err_cfg_cleared", 64'(err_cfg), 64'(0));
        wait_done(d0 + 1, 100);
        repeat (2) cycle();

        // Spurious pass_done in IDLE
        pd_force = 1'b1;
        cycle();
        pd_force = 1'b0;
        chk("t5_err_spurious", 64'(err_spurious), 64'(1));
        chk("t5_still_idle", 64'(cfg_ready), 64'(1));
        chk("t5_not_busy", 64'(busy), 64'(0));
        cycle();
        chk("t5_no_cmd", 64'(cmd_valid), 64'(0));

        // Abort coinciding with pass_done in WAIT of pass 3
        hs0 = n_hs; d0 = n_done;
        start_job(10, 3, 8, 1'b1);
        chk("t5_err_spurious_cleared", 64'(err_spurious), 64'(0));
        wait_hs(hs0 + 2, 50);
        pd_en = 1'b0;
        wait_hs(hs0 + 3, 50);
        abort = 1'b1;
        pd_force = 1'b1;
        cycle();
        abort = 1'b0;
        pd_force = 1'b0;
        chk("abort_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("abort_done", 64'(done), 64'(0));
        repeat (5) cycle();
        chk("abort_no_done", 64'(n_done - d0), 64'(0));
        chk("abort_err_spurious", 64'(err_spurious), 64'(0));
        chk("abort_pending_cmds", 64'(exp_q.size()), 64'(3));
        exp_q.delete();
        pd_en = 1'b1;

        // Asynchronous reset during ISSUE of pass 2
        hs0 = n_hs;
        start_job(10, 3, 8, 1'b1);
        wait_hs(hs0 + 1, 50);
        cmd_ready = 1'b0;
        wait_valid(50);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("arst_pending_cmds", 64'(exp_q.size()), 64'(5));
        exp_q.delete();
        pd_cnt = 0;
        pd_auto = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cmd_ready = 1'b1;
        cycle();
        hs0 = n_hs; d0 = n_done;
        start_job(10, 3, 8, 1'b1);
        wait_done(d0 + 1, 200);
        repeat (2) cycle();
        chk("t6_cmd_count", 64'(n_hs - hs0), 64'(6));
        chk("t6_done_count", 64'(n_done - d0), 64'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
